// File: rtl/bp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : bp_pkg                                                            |
// | Desc   : Shared types and counter encodings for the branch predictor.      |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
package bp_pkg;

  localparam int BP_BIT_W   = 32;
  localparam int BP_ENTRIES = 16;
  localparam int BP_IDX_W   = $clog2(BP_ENTRIES);
  localparam int BP_TAG_W   = BP_BIT_W - BP_IDX_W - 1;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'b00;
  localparam ctr_t WNT = 2'b01;
  localparam ctr_t WT  = 2'b10;
  localparam ctr_t ST  = 2'b11;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    ctr_t                ctr;
    logic [BP_BIT_W-1:0] target;
  } btb_entry_t;

endpackage
`default_nettype wire

// File: rtl/bp_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : bp_sat_counter                                                    |
// | Desc   : 2-bit saturating counter next-state logic (with force-to-ST).     |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module bp_sat_counter
  import bp_pkg::*;
(
  input  logic [1:0] i_ctr,
  input  logic       i_taken,
  input  logic       i_force_st,
  output logic [1:0] o_ctr_next
);

  always_comb begin
    o_ctr_next = i_ctr;
    if (i_force_st) begin
      o_ctr_next = ST;
    end else if (i_taken) begin
      if (i_ctr != ST) o_ctr_next = i_ctr + 2'd1;
    end else begin
      if (i_ctr != SNT) o_ctr_next = i_ctr - 2'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : branch_predictor                                                  |
// | Desc   : Direct-mapped BTB predictor, combinational lookup, trained from   |
// |          EX feedback. Define BP_STATS_EN for branch/mispredict counters.   |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module branch_predictor
  import bp_pkg::*;
#(
  parameter int BIT_W   = BP_BIT_W,
  parameter int ENTRIES = BP_ENTRIES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BIT_W-1:0] i_if_pc,
  input  logic             i_if_valid,
  output logic             o_pred_taken,
  output logic [BIT_W-1:0] o_pred_target,
  input  logic             i_fb_valid,
  input  logic             i_fb_stall,
  input  logic [BIT_W-1:0] i_fb_pc,
  input  logic             i_fb_jump,
  input  logic             i_fb_taken,
  input  logic [BIT_W-1:0] i_fb_target,
`ifdef BP_STATS_EN
  output logic [31:0]      o_stat_branches,
  output logic [31:0]      o_stat_mispredicts,
`endif
  input  logic             i_fb_mispredict
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = BIT_W - IDX_W - 1;

  btb_entry_t r_btb [ENTRIES];

  logic [IDX_W-1:0] w_if_idx;
  logic [IDX_W-1:0] w_fb_idx;
  logic [TAG_W-1:0] w_fb_tag;
  btb_entry_t       w_if_entry;
  btb_entry_t       w_fb_entry;
  btb_entry_t       w_wr_entry;
  logic             w_if_hit;
  logic             w_fb_hit;
  logic             w_train;
  logic             w_wr_en;
  logic [1:0]       w_ctr_next;

  // Bit 0 is never part of the index so 16-bit compressed PCs map cleanly.
  assign w_if_idx   = i_if_pc[IDX_W:1];
  assign w_fb_idx   = i_fb_pc[IDX_W:1];
  assign w_fb_tag   = i_fb_pc[BIT_W-1:IDX_W+1];
  assign w_if_entry = r_btb[w_if_idx];
  assign w_fb_entry = r_btb[w_fb_idx];
  assign w_if_hit   = w_if_entry.valid && (w_if_entry.tag == i_if_pc[BIT_W-1:IDX_W+1]);
  assign w_fb_hit   = w_fb_entry.valid && (w_fb_entry.tag == w_fb_tag);
  assign w_train    = i_fb_valid && !i_fb_stall;

  assign o_pred_taken  = i_if_valid && w_if_hit && w_if_entry.ctr[1];
  assign o_pred_target = o_pred_taken ? w_if_entry.target : i_if_pc;

  bp_sat_counter u_sat_counter (
    .i_ctr      (w_fb_entry.ctr),
    .i_taken    (i_fb_taken),
    .i_force_st (i_fb_jump),
    .o_ctr_next (w_ctr_next)
  );

  always_comb begin
    w_wr_en    = 1'b0;
    w_wr_entry = w_fb_entry;
    if (w_train) begin
      if (w_fb_hit) begin
        w_wr_en        = 1'b1;
        w_wr_entry.ctr = w_ctr_next;
        if (i_fb_taken || i_fb_jump) w_wr_entry.target = i_fb_target;
      end else if (i_fb_taken) begin
        w_wr_en           = 1'b1;
        w_wr_entry.valid  = 1'b1;
        w_wr_entry.tag    = w_fb_tag;
        w_wr_entry.ctr    = i_fb_jump ? ST : WT;
        w_wr_entry.target = i_fb_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_btb[i] <= '{valid: 1'b0, tag: '0, ctr: WNT, target: '0};
      end
    end else if (w_wr_en) begin
      r_btb[w_fb_idx] <= w_wr_entry;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_mispredicts;
  logic [1:0]  w_unused;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_branches    <= '0;
      r_stat_mispredicts <= '0;
    end else if (w_train) begin
      r_stat_branches <= r_stat_branches + 32'd1;
      if (i_fb_mispredict) r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
    end
  end

  assign o_stat_branches    = r_stat_branches;
  assign o_stat_mispredicts = r_stat_mispredicts;
  assign w_unused           = {i_if_pc[0], i_fb_pc[0]};
`else
  logic [2:0] w_unused;
  assign w_unused = {i_fb_mispredict, i_if_pc[0], i_fb_pc[0]};
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_branch_predictor                                               |
// | Desc   : Directed scoreboard bench for branch_predictor (BP_STATS_EN aware).|
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] if_pc = '0;
  logic        if_valid = 1'b0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        fb_valid = 1'b0;
  logic        fb_stall = 1'b0;
  logic [31:0] fb_pc = '0;
  logic        fb_jump = 1'b0;
  logic        fb_taken = 1'b0;
  logic [31:0] fb_target = '0;
  logic        fb_mispredict = 1'b0;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  logic        probe = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  typedef struct {
    logic        taken;
    logic [31:0] target;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_if_pc           (if_pc),
    .i_if_valid        (if_valid),
    .o_pred_taken      (pred_taken),
    .o_pred_target     (pred_target),
    .i_fb_valid        (fb_valid),
    .i_fb_stall        (fb_stall),
    .i_fb_pc           (fb_pc),
    .i_fb_jump         (fb_jump),
    .i_fb_taken        (fb_taken),
    .i_fb_target       (fb_target),
`ifdef BP_STATS_EN
    .o_stat_branches   (stat_branches),
    .o_stat_mispredicts(stat_mispredicts),
`endif
    .i_fb_mispredict   (fb_mispredict)
  );

  // Monitor: pops one expectation per probed cycle, sampling on the falling edge.
  always @(negedge clk) begin
    if (probe) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_underflow: pc=%h got taken=%0b target=%h, required an expectation", if_pc, pred_taken, pred_target);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (pred_taken !== e.taken || pred_target !== e.target) begin
          n_fail++;
          $display("FAIL lookup pc=%h valid=%0b: got taken=%0b target=%h, required taken=%0b target=%h",
                   if_pc, if_valid, pred_taken, pred_target, e.taken, e.target);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle: optional probed lookup plus optional feedback, issued together.
  task automatic cyc(input logic lk, input logic [31:0] pc, input logic vld,
                     input logic et, input logic [31:0] etgt,
                     input logic fv, input logic fs, input logic [31:0] fpc,
                     input logic fj, input logic ft, input logic [31:0] ftgt,
                     input logic fm);
    exp_t e;
    if_pc = pc; if_valid = vld; probe = lk;
    fb_valid = fv; fb_stall = fs; fb_pc = fpc; fb_jump = fj;
    fb_taken = ft; fb_target = ftgt; fb_mispredict = fm;
    if (lk) begin
      e.taken = et; e.target = etgt;
      sb_q.push_back(e);
    end
    step();
    probe = 1'b0; if_valid = 1'b0; fb_valid = 1'b0; fb_stall = 1'b0; fb_mispredict = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc, input logic et, input logic [31:0] etgt);
    cyc(1'b1, pc, 1'b1, et, etgt, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic train(input logic [31:0] pc, input logic jmp, input logic tk, input logic [31:0] tgt);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, pc, jmp, tk, tgt, 1'b0);
  endtask

  initial begin
    // Lookup while reset is held: outputs are pass-through.
    step();
    lookup(32'h100, 1'b0, 32'h100);
    rst_n = 1'b1;

    lookup(32'h100, 1'b0, 32'h100);
    train(32'h100, 1'b0, 1'b1, 32'h80);           // miss, taken -> WT
    lookup(32'h100, 1'b1, 32'h80);
    train(32'h100, 1'b0, 1'b0, 32'h0);            // WT -> WNT
    lookup(32'h100, 1'b0, 32'h100);

    for (int i = 0; i < 4; i++) train(32'h100, 1'b0, 1'b1, 32'h80);  // -> ST
    lookup(32'h100, 1'b1, 32'h80);
    train(32'h100, 1'b0, 1'b0, 32'h0);            // ST -> WT
    lookup(32'h100, 1'b1, 32'h80);
    train(32'h100, 1'b0, 1'b0, 32'h0);            // WT -> WNT
    lookup(32'h100, 1'b0, 32'h100);
    for (int i = 0; i < 5; i++) train(32'h100, 1'b0, 1'b0, 32'h0);   // -> SNT, no wrap
    lookup(32'h100, 1'b0, 32'h100);
    train(32'h100, 1'b0, 1'b1, 32'h84);           // SNT -> WNT, still not taken
    lookup(32'h100, 1'b0, 32'h100);

    // Hit jump forces ST: one not-taken afterwards still predicts taken.
    train(32'h100, 1'b1, 1'b1, 32'h90);
    train(32'h100, 1'b0, 1'b0, 32'h0);
    lookup(32'h100, 1'b1, 32'h90);

    // Compressed jump at index 1; 0x200 maps to index 0 and misses.
    train(32'h202, 1'b1, 1'b1, 32'h400);
    lookup(32'h202, 1'b1, 32'h400);
    lookup(32'h200, 1'b0, 32'h200);

    // Alias: 0x120 shares index 0 with 0x100 and replaces it.
    train(32'h120, 1'b0, 1'b1, 32'h300);
    lookup(32'h100, 1'b0, 32'h100);
    lookup(32'h120, 1'b1, 32'h300);
    train(32'h140, 1'b0, 1'b0, 32'h0);            // miss not-taken: no allocation
    lookup(32'h120, 1'b1, 32'h300);
    lookup(32'h140, 1'b0, 32'h140);

    // Lookup with if_valid low never predicts taken.
    cyc(1'b1, 32'h120, 1'b0, 1'b0, 32'h120, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Stalled feedback is ignored (a real WT->WNT would flip the prediction).
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h120, 1'b0, 1'b0, 32'h0, 1'b1);
    lookup(32'h120, 1'b1, 32'h300);

    // Same-cycle lookup and update: old contents now, new contents next cycle.
    cyc(1'b1, 32'h120, 1'b1, 1'b1, 32'h300, 1'b1, 1'b0, 32'h120, 1'b0, 1'b0, 32'h0, 1'b0);
    lookup(32'h120, 1'b0, 32'h120);

    // Reset asserted with feedback present: reset wins and clears everything.
    train(32'h120, 1'b0, 1'b1, 32'h300);
    rst_n = 1'b0;
    train(32'h120, 1'b0, 1'b1, 32'h300);
    rst_n = 1'b1;
    lookup(32'h120, 1'b0, 32'h120);
    lookup(32'h202, 1'b0, 32'h202);

`ifdef BP_STATS_EN
    n_checks++;
    if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
      n_fail++;
      $display("FAIL stats_reset: got %0d/%0d, required 0/0", stat_branches, stat_mispredicts);
    end
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 1'b0, 1'b1, 32'h80, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h104, 1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++;
    if (stat_branches !== 32'd3 || stat_mispredicts !== 32'd1) begin
      n_fail++;
      $display("FAIL stats_count: got %0d/%0d, required 3/1", stat_branches, stat_mispredicts);
    end
`endif

    step();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish, required finish before 100000");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- IF-side dynamic branch predictor. It consumes the prediction-evaluation feedback that the execute stage produces, and generates the predicted-taken flag and target that travel down the pipeline alongside each fetched instruction.
- Structure: direct-mapped branch target buffer (BTB), where each entry holds a 2-bit saturating counter.
- Lookup is combinational on the fetch PC. Training is sequential on resolved branch/jump feedback.
- Supports 16-bit compressed instructions, so the table is indexed from PC bit 1.

Parameters:
- BIT_W, 32, datapath/PC width.
- ENTRIES, 16, number of BTB entries; must be a power of 2, at least 2.
- IDX_W, $clog2(ENTRIES), index width (localparam).
- TAG_W, BIT_W-IDX_W-1, tag width, taken from PC[BIT_W-1:IDX_W+1] (localparam).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- if_pc  in  BIT_W  PC of the instruction being fetched.
- if_valid  in  1  fetch slot holds a real instruction.
- pred_taken  out  1  prediction that the instruction at if_pc is a taken branch/jump.
- pred_target  out  BIT_W  predicted next PC; equals if_pc when pred_taken=0.
- fb_valid  in  1  EX has resolved a branch or jump this cycle.
- fb_stall  in  1  EX stage stalled; suppresses training.
- fb_pc  in  BIT_W  PC of the resolved instruction.
- fb_jump  in  1  resolved instruction is jal/jalr.
- fb_taken  in  1  actual branch outcome (1 for jumps).
- fb_target  in  BIT_W  actual taken target.
- fb_mispredict  in  1  EX correction asserted (used only by the optional feature).

Behaviour:
- Entry fields: valid, tag[TAG_W], ctr[2], target[BIT_W].
  - Index: PC[IDX_W:1].
  - Hit: valid && tag == PC[BIT_W-1:IDX_W+1].
- Reset (rst_n=0 at posedge):
  - All entries: valid=0, ctr=WNT (01), tag=0, target=0.
  - Outputs are combinational, so during and after reset: pred_taken=0 and pred_target=if_pc.
- Lookup (zero latency):
  - pred_taken = if_valid && hit(if_pc) && ctr[1].
  - pred_target = pred_taken ? entry.target : if_pc.
- Training happens at posedge only when fb_valid && !fb_stall && rst_n.
  - Hit, fb_taken=1: ctr = sat_inc(ctr); target = fb_target.
  - Hit, fb_taken=0: ctr = sat_dec(ctr); target is unchanged.
  - Hit, fb_jump=1: ctr forced to ST (11); target = fb_target.
  - Miss, fb_taken=1: allocate/overwrite the entry with valid=1, tag, target=fb_target; ctr = fb_jump ? ST : WT (10).
  - Miss, fb_taken=0: no allocation; table unchanged.
- Saturation:
  - Counter is 2-bit unsigned.
  - inc at 11 stays 11; dec at 00 stays 00. No wrap.
- Simultaneous lookup and update to the same index in one cycle: the lookup sees the pre-update contents. The update becomes visible the next cycle; there is no bypass.
- fb_valid with fb_stall=1: no table change (the stalled feedback is re-presented later).
- Aliasing: a tag mismatch at the same index is a miss, and allocation replaces the entry.
- Reset mid-training: reset wins; the table is cleared.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined: adds outputs stat_branches[32] and stat_mispredicts[32], both reset to 0.
  - stat_branches increments on each trained feedback (fb_valid && !fb_stall).
  - stat_mispredicts increments when the trained feedback also has fb_mispredict=1.
  - Both wrap modulo 2^32.
- Undefined: the ports and counters do not exist; the predictor's behaviour is otherwise identical.

Decomposition:
- Package bp_pkg holds:
  - Counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - Packed btb_entry_t {valid, tag, ctr, target}.
- Sub-module bp_sat_counter: combinational 2-bit next-state logic with inputs ctr, taken, force_st and output ctr_next. It is instantiated once, on the training path.

Test Plan:
- Reset, then if_pc=0x100, if_valid=1 -> pred_taken=0, pred_target=0x100.
- Feedback fb_pc=0x100, fb_taken=1, fb_target=0x80 (branch) -> next cycle pred_taken=1, pred_target=0x80 (ctr=WT). One not-taken feedback -> ctr=WNT, pred_taken=0.
- Saturation: 4 taken feedbacks on 0x100 -> ctr=ST. Then 1 not-taken -> still predicts taken (WT); 2nd not-taken -> WNT, not taken. 5 not-taken -> ctr=SNT with no underflow.
- Jump fb_jump=1 at 0x202 (compressed, index bit 1 set), target 0x400 -> entry ctr=ST. Lookup at 0x200 is a different index -> no hit.
- Alias: train 0x100 taken, then train 0x100+2*ENTRIES (=0x120) taken with target 0x300 -> lookup 0x100 misses, lookup 0x120 predicts 0x300.
- fb_stall=1 with fb_valid=1 -> table unchanged. Same-cycle lookup and update of 0x100 -> old prediction that cycle, new one the next cycle. With BP_STATS_EN, 3 trained feedbacks (1 with fb_mispredict=1) -> stat_branches=3, stat_mispredicts=1.
